uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters sharing one async_transmitter (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 1023: WAIT_BUSY cycle limit (used only with the Configuration macro).
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port KEY, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port req, input, N_REQ bits: per-requester byte-send request, level.
REQ-006 The block SHALL have port data_in, input, 8*N_REQ bits: byte i at bits [8i+7:8i].
REQ-007 The block SHALL have port ack, output, N_REQ bits: one-cycle pulse, byte of requester i accepted.
REQ-008 The block SHALL have port TxD_start, output, 1 bit: to the transmitter, one-cycle start pulse.
REQ-009 The block SHALL have port TxD_data, output, 8 bits: to the transmitter, registered byte.
REQ-010 The block SHALL have port TxD_busy, input, 1 bit: from the transmitter.
REQ-011 The block SHALL have port grant_id, output, clog2(N_REQ) bits: index of the current or last granted requester.
REQ-012 The block SHALL have port active, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky watchdog flag.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_IDLE.
REQ-015 In IDLE, with TxD_busy=0 and any req high, the block SHALL pick the first requesting index after last_grant, wrapping from N_REQ-1 to 0, and go to LAUNCH next cycle.
REQ-016 In IDLE with TxD_busy=1, the block SHALL make no grant and stay in IDLE.
REQ-017 On the IDLE->LAUNCH edge the block SHALL register TxD_data=data_in slice, grant_id=index and last_grant=index, and assert ack[index] for exactly the LAUNCH cycle.
REQ-018 In LAUNCH the block SHALL assert TxD_start=1 for exactly one cycle and then go to WAIT_BUSY.
REQ-019 Latency: req sampled in IDLE at cycle T SHALL give ack and TxD_start at T+1.
REQ-020 In WAIT_BUSY, TxD_busy=1 SHALL move the FSM to WAIT_IDLE; otherwise the FSM SHALL hold.
REQ-021 In WAIT_IDLE, TxD_busy=0 SHALL move the FSM to IDLE, so the next grant can start no earlier than the following cycle.
REQ-022 TxD_data SHALL stay stable from LAUNCH until the next grant.
REQ-023 A requester SHALL hold req and its data stable until ack; req dropped before grant SHALL be ignored with no ack; req still high after ack SHALL be a new byte request.
REQ-024 With all req high continuously, grants SHALL rotate 0,1,2,...,N_REQ-1,0 and no requester SHALL wait more than N_REQ transfers.
REQ-025 A req arriving mid-transfer SHALL wait for IDLE; no request SHALL be lost or acked twice.

Reset
REQ-026 KEY=0 at a clock edge SHALL force state=IDLE, ack=0, TxD_start=0, TxD_data=8'h00, grant_id=0, last_grant=N_REQ-1 (requester 0 first), active=0, timeout_err=0 and the watchdog counter to 0.
REQ-027 Reset asserted mid-transfer SHALL abort the sequence with no ack and no TxD_start; transmitter state SHALL NOT be touched.

Configuration
REQ-028 With macro UART_TX_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY.
REQ-029 With the macro defined, if TIMEOUT cycles elapse without TxD_busy, the FSM SHALL return to IDLE and set timeout_err=1 until reset.
REQ-030 With the macro defined, the counter SHALL clear on leaving WAIT_BUSY.
REQ-031 Without the macro, no counter logic SHALL exist, timeout_err SHALL be constant 0 and WAIT_BUSY SHALL wait indefinitely.

Verification
REQ-032 Scenario: reset, then req=4'b0001 with byte0=8'h41 -> at T+1 ack=4'b0001, TxD_start=1 and TxD_data=8'h41; busy model then completes and active returns to 0.
REQ-033 Scenario: req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13 -> TxD_data order 10,11,12,13,10 and grant_id sequence 0,1,2,3,0.
REQ-034 Scenario: req[2] raised while requester 0 is in WAIT_IDLE -> no TxD_start until TxD_busy falls, then grant_id=2 one cycle after IDLE.
REQ-035 Scenario: KEY=0 for one cycle during LAUNCH -> next cycle TxD_start=0, ack=0, active=0; first grant after reset goes to requester 0.
REQ-036 Scenario: TxD_busy stuck high after reset -> no ack and no TxD_start while busy is high.
REQ-037 Scenario: with UART_TX_ARB_TIMEOUT_EN and TIMEOUT=15, TxD_busy never rises -> timeout_err=1 after 15 WAIT_BUSY cycles, FSM back in IDLE; without the macro timeout_err stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the transmitter and the round-robin byte arbiter.
// Latency: none, wires only.
// Backpressure: TxD_busy from the transmitter, per-requester ack pulses back to requesters.
//
// Signals:
//   req        requester -> arbiter   level request per requester
//   data_in    requester -> arbiter   byte i at [8i+7:8i]
//   ack        arbiter -> requester   one-cycle accept pulse
//   TxD_start  arbiter -> transmitter one-cycle start pulse
//   TxD_data   arbiter -> transmitter registered byte
//   TxD_busy   transmitter -> arbiter
//   grant_id   index of current/last granted requester
//   active     arbiter not idle
//   timeout_err sticky watchdog flag
// Modports: slave = arbiter view, master = requesters + transmitter view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] data_in;
  logic [N_REQ-1:0]   ack;
  logic               TxD_start;
  logic [7:0]         TxD_data;
  logic               TxD_busy;
  logic [GW-1:0]      grant_id;
  logic               active;
  logic               timeout_err;

  modport slave (
    input  req,
    input  data_in,
    input  TxD_busy,
    output ack,
    output TxD_start,
    output TxD_data,
    output grant_id,
    output active,
    output timeout_err
  );

  modport master (
    output req,
    output data_in,
    output TxD_busy,
    input  ack,
    input  TxD_start,
    input  TxD_data,
    input  grant_id,
    input  active,
    input  timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one async_transmitter between N_REQ byte requesters.
// Latency: request sampled in IDLE at cycle T gives ack and TxD_start at T+1.
// Backpressure: no grant while TxD_busy is high; requesters hold req/data until ack.
//
// Ports:
//   CLOCK_50  single clock, all logic on its rising edge
//   KEY       synchronous active-low reset
//   bus       uart_tx_arbiter_if.slave (req, data_in, ack, TxD_start, TxD_data,
//             TxD_busy, grant_id, active, timeout_err)
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a WAIT_BUSY watchdog
// that gives up after TIMEOUT cycles and raises the sticky timeout_err flag.
// Without it, WAIT_BUSY waits indefinitely and timeout_err is tied low.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             CLOCK_50,
  input  logic             KEY,
  uart_tx_arbiter_if.slave bus
);

  localparam int             GW       = $clog2(N_REQ);
  // Pointer starts at the top index so requester 0 is served first after reset.
  localparam logic [GW-1:0]  LAST_RST = GW'(N_REQ - 1);

  // Parameter sanity check at elaboration.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [GW-1:0]     last_grant;
  logic [N_REQ-1:0]  ack_q;
  logic [7:0]        txd_data_q;
  logic [GW-1:0]     grant_id_q;

  logic              pick_vld;
  logic [GW-1:0]     pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic [7:0]        pick_dat;
  logic              grant;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int             WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]  WD_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0]     wd_cnt;
  logic              timeout_hit;
  logic              timeout_err_q;
`endif

  // Round-robin pick. Requesters above last_grant outrank those at or below it;
  // within each group the lowest index wins. Each loop runs high-to-low so the
  // last assignment is the lowest requesting index; the second loop overrides
  // the first, which gives the "first requesting index after last_grant, with
  // wrap" order.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    pick_dat = 8'h00;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (i <= int'(last_grant))) begin
        pick_vld   = 1'b1;
        pick_idx   = i[GW-1:0];
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_dat   = bus.data_in[8*i +: 8];
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (i > int'(last_grant))) begin
        pick_vld   = 1'b1;
        pick_idx   = i[GW-1:0];
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_dat   = bus.data_in[8*i +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        // A busy transmitter blocks any grant, even with requests pending.
        if (!bus.TxD_busy && pick_vld) begin
          grant     = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.TxD_busy) begin
          state_nxt = WAIT_IDLE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        // wd_cnt counts completed WAIT_BUSY cycles, so the TIMEOUT-th cycle
        // without busy sees wd_cnt == TIMEOUT-1.
        else if (wd_cnt == WD_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
`endif
      end
      WAIT_IDLE: begin
        if (!bus.TxD_busy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant side effects all land on the IDLE->LAUNCH edge, so ack lines up with
  // TxD_start and TxD_data holds its byte until the next grant.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      ack_q      <= '0;
      txd_data_q <= 8'h00;
      grant_id_q <= '0;
      last_grant <= LAST_RST;
    end else begin
      ack_q <= '0;
      if (grant) begin
        ack_q      <= pick_oh;
        txd_data_q <= pick_dat;
        grant_id_q <= pick_idx;
        last_grant <= pick_idx;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Watchdog runs only while staying in WAIT_BUSY and clears on any exit.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      wd_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state == WAIT_BUSY && state_nxt == WAIT_BUSY) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.ack       = ack_q;
  assign bus.TxD_start = (state == LAUNCH);
  assign bus.TxD_data  = txd_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.active    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter busy model.
// Latency: n/a.
// Backpressure: busy model raises TxD_busy on TxD_start for three cycles.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;

  logic clk;
  logic key;
  int   n_chk;
  int   n_fail;
  int   busy_mode;   // 0: never busy, 1: transmitter model, 2: stuck busy
  int   busy_cnt;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(
    .N_REQ   (N_REQ),
    .TIMEOUT (15)
  ) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy asserted from the LAUNCH cycle for three cycles.
  initial begin
    bus.TxD_busy = 1'b0;
    busy_cnt     = 0;
    forever begin
      @(posedge clk);
      #1;
      case (busy_mode)
        1: begin
          if (busy_cnt > 0) begin
            busy_cnt--;
            bus.TxD_busy = (busy_cnt != 0);
          end else if (bus.TxD_start) begin
            bus.TxD_busy = 1'b1;
            busy_cnt     = 3;
          end else begin
            bus.TxD_busy = 1'b0;
          end
        end
        2: begin
          bus.TxD_busy = 1'b1;
          busy_cnt     = 0;
        end
        default: begin
          bus.TxD_busy = 1'b0;
          busy_cnt     = 0;
        end
      endcase
    end
  end

  task automatic do_reset();
    key = 1'b0;
    tick();
    tick();
    key = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!bus.TxD_start && n < 40) begin
      tick();
      n++;
    end
    chk_eq(tag, bus.TxD_start, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.active && n < 40) begin
      tick();
      n++;
    end
    chk_eq(tag, bus.active, 1'b0);
  endtask

  logic [7:0] exp_bytes [5];

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    busy_mode   = 1;
    key         = 1'b0;
    bus.req     = '0;
    bus.data_in = '0;

    // Reset state
    do_reset();
    chk_eq("rst_ack",       bus.ack, 4'b0000);
    chk_eq("rst_start",     bus.TxD_start, 1'b0);
    chk_eq("rst_data",      bus.TxD_data, 8'h00);
    chk_eq("rst_grant_id",  bus.grant_id, 2'd0);
    chk_eq("rst_active",    bus.active, 1'b0);
    chk_eq("rst_timeout",   bus.timeout_err, 1'b0);

    // Single byte from requester 0, exact T+1 latency
    bus.data_in = 32'hAAAA_AA41;
    bus.req     = 4'b0001;
    tick();
    chk_eq("s1_ack",      bus.ack, 4'b0001);
    chk_eq("s1_start",    bus.TxD_start, 1'b1);
    chk_eq("s1_data",     bus.TxD_data, 8'h41);
    chk_eq("s1_grant_id", bus.grant_id, 2'd0);
    chk_eq("s1_active",   bus.active, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_eq("s1_ack_pulse",   bus.ack, 4'b0000);
    chk_eq("s1_start_pulse", bus.TxD_start, 1'b0);
    wait_idle("s1_idle");
    chk_eq("s1_data_hold", bus.TxD_data, 8'h41);

    // All requesters held high: strict rotation starting at 0
    do_reset();
    exp_bytes   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    bus.data_in = 32'h1312_1110;
    bus.req     = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start($sformatf("rr_start_%0d", k));
      chk_eq($sformatf("rr_data_%0d", k),  bus.TxD_data, exp_bytes[k]);
      chk_eq($sformatf("rr_gid_%0d", k),   bus.grant_id, 32'(k % 4));
      chk_eq($sformatf("rr_ack_%0d", k),   bus.ack, 32'(1 << (k % 4)));
      tick();
    end
    bus.req = 4'b0000;
    wait_idle("rr_idle");

    // Requester 2 arrives while requester 0 is in WAIT_IDLE
    do_reset();
    bus.data_in = 32'h0077_0055;
    bus.req     = 4'b0001;
    wait_start("mid_start0");
    chk_eq("mid_gid0", bus.grant_id, 2'd0);
    bus.req = 4'b0000;
    tick();                       // WAIT_BUSY
    tick();                       // WAIT_IDLE
    bus.req = 4'b0100;
    tick();                       // still WAIT_IDLE, busy high
    chk_eq("mid_no_start_busy", bus.TxD_start, 1'b0);
    chk_eq("mid_active_busy",   bus.active, 1'b1);
    tick();                       // busy fell: IDLE
    chk_eq("mid_no_start_idle", bus.TxD_start, 1'b0);
    chk_eq("mid_idle",          bus.active, 1'b0);
    tick();                       // grant one cycle after IDLE
    chk_eq("mid_start2", bus.TxD_start, 1'b1);
    chk_eq("mid_gid2",   bus.grant_id, 2'd2);
    chk_eq("mid_data2",  bus.TxD_data, 8'h77);
    chk_eq("mid_ack2",   bus.ack, 4'b0100);
    bus.req = 4'b0000;
    wait_idle("mid_idle_end");

    // Reset pulse during LAUNCH aborts and rewinds the pointer
    bus.data_in = 32'h0033_2211;
    bus.req     = 4'b0010;        // last_grant is 2, only requester 1 asks
    wait_start("rl_start1");
    chk_eq("rl_gid1", bus.grant_id, 2'd1);
    key = 1'b0;
    tick();
    key = 1'b1;
    chk_eq("rl_start_abort",  bus.TxD_start, 1'b0);
    chk_eq("rl_ack_abort",    bus.ack, 4'b0000);
    chk_eq("rl_active_abort", bus.active, 1'b0);
    bus.req = 4'b0111;            // without pointer reset this would pick 2
    wait_start("rl_start_after");
    chk_eq("rl_gid_after",  bus.grant_id, 2'd0);
    chk_eq("rl_ack_after",  bus.ack, 4'b0001);
    chk_eq("rl_data_after", bus.TxD_data, 8'h11);
    bus.req = 4'b0000;
    wait_idle("rl_idle");

    // Transmitter stuck busy: nothing granted
    busy_mode = 2;
    do_reset();
    bus.data_in = 32'h4444_4444;
    bus.req     = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_eq($sformatf("stuck_%0d", k), {bus.ack, bus.TxD_start}, 5'b0);
    end
    busy_mode = 1;
    wait_start("stuck_release");
    chk_eq("stuck_release_gid", bus.grant_id, 2'd0);
    bus.req = 4'b0000;
    wait_idle("stuck_idle");

    // Busy never rises after a start
    busy_mode = 0;
    do_reset();
    bus.data_in = 32'h0000_005A;
    bus.req     = 4'b0001;
    wait_start("wd_start");
    bus.req = 4'b0000;
    repeat (15) tick();           // 15th WAIT_BUSY cycle
    chk_eq("wd_active_15",  bus.active, 1'b1);
    chk_eq("wd_err_15",     bus.timeout_err, 1'b0);
    tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk_eq("wd_active_16",  bus.active, 1'b0);
    chk_eq("wd_err_16",     bus.timeout_err, 1'b1);
    repeat (5) tick();
    chk_eq("wd_err_sticky", bus.timeout_err, 1'b1);
`else
    chk_eq("wd_active_16",  bus.active, 1'b1);
    chk_eq("wd_err_16",     bus.timeout_err, 1'b0);
    repeat (40) tick();
    chk_eq("wd_still_wait", bus.active, 1'b1);
    chk_eq("wd_err_late",   bus.timeout_err, 1'b0);
`endif
    do_reset();
    chk_eq("wd_err_cleared", bus.timeout_err, 1'b0);
    chk_eq("wd_idle_reset",  bus.active, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
